// File: rtl/wca_reg_arbiter.sv
// Two-requester round-robin arbiter in front of NREG 8-bit register cores.
// Each access walks IDLE -> ACCESS (one cycle) -> ACK (until the owner drops Req).
module wca_reg_arbiter #(
  parameter int NREG = 8
) (
  input  logic              i_clock,
  input  logic              i_aclr_n,
  input  logic              i_req_a,
  input  logic              i_wr_a,
  input  logic [2:0]        i_addr_a,
  input  logic [7:0]        i_data_a,
  output logic              o_ack_a,
  output logic [7:0]        o_rd_data_a,
  input  logic              i_req_b,
  input  logic              i_wr_b,
  input  logic [2:0]        i_addr_b,
  input  logic [7:0]        i_data_b,
  output logic              o_ack_b,
  output logic [7:0]        o_rd_data_b,
  output logic [NREG-1:0]   o_reg_en,
  output logic [7:0]        o_reg_data,
  input  logic [8*NREG-1:0] i_reg_q,
  output logic              o_busy,
  output logic              o_owner
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_last_b;
  logic            r_wr;
  logic [2:0]      r_addr;
  logic [NREG-1:0] r_reg_en;
  logic [7:0]      r_reg_data;
  logic            r_ack_a;
  logic            r_ack_b;
  logic [7:0]      r_rd_a;
  logic [7:0]      r_rd_b;
  logic            r_busy;

  logic            w_grant_b;
  logic            w_wr;
  logic [2:0]      w_addr;
  logic [7:0]      w_data;
  logic            w_owner_req;
  logic [NREG-1:0] w_sel_en;
  logic [7:0]      w_q [NREG];
  logic [7:0]      w_rd_byte;

  // On a tie the requester that was not served last wins.
  assign w_grant_b   = i_req_b && (!i_req_a || !r_last_b);
  assign w_wr        = w_grant_b ? i_wr_b   : i_wr_a;
  assign w_addr      = w_grant_b ? i_addr_b : i_addr_a;
  assign w_data      = w_grant_b ? i_data_b : i_data_a;
  assign w_owner_req = r_owner ? i_req_b : i_req_a;

  // Addresses >= NREG match no enable bit and read back as zero.
  genvar gi;
  for (gi = 0; gi < NREG; gi++) begin : g_reg
    assign w_q[gi]      = i_reg_q[8*gi +: 8];
    assign w_sel_en[gi] = w_wr && (w_addr == 3'(gi));
  end

  always_comb begin
    w_rd_byte = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (r_addr == 3'(i)) w_rd_byte = w_q[i];
    end
  end

  always_ff @(posedge i_clock or negedge i_aclr_n) begin
    if (!i_aclr_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_last_b   <= 1'b1;
      r_wr       <= 1'b0;
      r_addr     <= 3'd0;
      r_reg_en   <= '0;
      r_reg_data <= 8'h00;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_rd_a     <= 8'h00;
      r_rd_b     <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_a || i_req_b) begin
            r_state  <= ST_ACCESS;
            r_busy   <= 1'b1;
            r_owner  <= w_grant_b;
            r_last_b <= w_grant_b;
            r_wr     <= w_wr;
            r_addr   <= w_addr;
            r_reg_en <= w_sel_en;
            if (w_wr) r_reg_data <= w_data;
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_ACK;
          r_reg_en <= '0;
          if (r_owner) r_ack_b <= 1'b1;
          else         r_ack_a <= 1'b1;
          if (!r_wr) begin
            if (r_owner) r_rd_b <= w_rd_byte;
            else         r_rd_a <= w_rd_byte;
          end
        end
        ST_ACK: begin
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack_a     = r_ack_a;
  assign o_ack_b     = r_ack_b;
  assign o_rd_data_a = r_rd_a;
  assign o_rd_data_b = r_rd_b;
  assign o_reg_en    = r_reg_en;
  assign o_reg_data  = r_reg_data;
  assign o_busy      = r_busy;
  assign o_owner     = r_owner;

endmodule

// File: tb/tb_wca_reg_arbiter.sv
// Bench for wca_reg_arbiter: an 8-register instance checked by a scoreboard monitor,
// plus a 4-register instance on the same inputs for out-of-range addressing.
module tb_wca_reg_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_a, wr_a, req_b, wr_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic [7:0] core [8];
  logic [63:0] reg_q;

  logic       ack_a, ack_b, busy, owner;
  logic [7:0] rd_a, rd_b, reg_data, reg_en;
  logic       ack_a4, ack_b4, busy4, owner4;
  logic [7:0] rd_a4, rd_b4, reg_data4;
  logic [3:0] reg_en4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         is_b;
    bit         wr;
    logic [7:0] en;
    logic [7:0] data;
    logic [7:0] rd;
  } exp_t;
  exp_t exp_q[$];

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < 8; i++) reg_q[8*i +: 8] = core[i];
  end

  wca_reg_arbiter #(.NREG(8)) dut (
    .i_clock(clk), .i_aclr_n(rst_n),
    .i_req_a(req_a), .i_wr_a(wr_a), .i_addr_a(addr_a), .i_data_a(data_a),
    .o_ack_a(ack_a), .o_rd_data_a(rd_a),
    .i_req_b(req_b), .i_wr_b(wr_b), .i_addr_b(addr_b), .i_data_b(data_b),
    .o_ack_b(ack_b), .o_rd_data_b(rd_b),
    .o_reg_en(reg_en), .o_reg_data(reg_data), .i_reg_q(reg_q),
    .o_busy(busy), .o_owner(owner)
  );

  wca_reg_arbiter #(.NREG(4)) dut4 (
    .i_clock(clk), .i_aclr_n(rst_n),
    .i_req_a(req_a), .i_wr_a(wr_a), .i_addr_a(addr_a), .i_data_a(data_a),
    .o_ack_a(ack_a4), .o_rd_data_a(rd_a4),
    .i_req_b(req_b), .i_wr_b(wr_b), .i_addr_b(addr_b), .i_data_b(data_b),
    .o_ack_b(ack_b4), .o_rd_data_b(rd_b4),
    .o_reg_en(reg_en4), .o_reg_data(reg_data4), .i_reg_q(reg_q[31:0]),
    .o_busy(busy4), .o_owner(owner4)
  );

  // Expected outcome of one access on the 8-register instance.
  function automatic exp_t mk(input bit is_b, input bit wr, input logic [2:0] addr,
                              input logic [7:0] data);
    exp_t e;
    e.is_b = is_b;
    e.wr   = wr;
    e.en   = wr ? (8'h01 << addr) : 8'h00;
    e.data = data;
    e.rd   = core[addr];
    return e;
  endfunction

  // Scoreboard: pops one expectation on every rising acknowledge.
  task automatic monitor();
    logic pa = 1'b0, pb = 1'b0;
    int en_cnt = 0;
    logic [7:0] en_val = 8'h00, en_dat = 8'h00, rd;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cnt = 0; pa = 1'b0; pb = 1'b0;
      end else begin
        if (reg_en != 8'h00) begin
          en_cnt++; en_val = reg_en; en_dat = reg_data;
          n_cmp++;
          if ($countones(reg_en) != 1) begin
            n_err++; $display("FAIL sb_onehot: reg_en=%b, required exactly one bit", reg_en);
          end
        end
        if ((ack_a && !pa) || (ack_b && !pb)) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_unexpected: ack_a=%b ack_b=%b with nothing pending", ack_a, ack_b);
          end else begin
            e = exp_q.pop_front();
            if (ack_b !== e.is_b || ack_a !== !e.is_b || owner !== e.is_b) begin
              n_err++;
              $display("FAIL sb_grant: ack_a=%b ack_b=%b owner=%b, required owner=%b", ack_a, ack_b, owner, e.is_b);
            end
            n_cmp++;
            if (en_cnt != (e.wr ? 1 : 0) || (e.wr && (en_val !== e.en || en_dat !== e.data))) begin
              n_err++;
              $display("FAIL sb_write: pulses=%0d en=%b data=%h, required pulses=%0d en=%b data=%h",
                       en_cnt, en_val, en_dat, e.wr ? 1 : 0, e.en, e.data);
            end
            if (!e.wr) begin
              n_cmp++;
              rd = e.is_b ? rd_b : rd_a;
              if (rd !== e.rd) begin
                n_err++; $display("FAIL sb_read: is_b=%b rd=%h, required %h", e.is_b, rd, e.rd);
              end
            end
          end
          en_cnt = 0;
        end
        pa = ack_a; pb = ack_b;
      end
    end
  endtask

  task automatic drive(input bit is_b, input bit wr, input logic [2:0] addr, input logic [7:0] data);
    if (is_b) begin req_b = 1'b1; wr_b = wr; addr_b = addr; data_b = data; end
    else      begin req_a = 1'b1; wr_a = wr; addr_a = addr; data_a = data; end
  endtask

  task automatic do_access(input bit is_b, input bit wr, input logic [2:0] addr,
                           input logic [7:0] data, input int hold);
    bit got = 1'b0;
    exp_q.push_back(mk(is_b, wr, addr, data));
    @(posedge clk); #1;
    drive(is_b, wr, addr, data);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_b ? ack_b : ack_a;
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL ack_timeout: requester %s ack=0 after 20 cycles, required 1", is_b ? "B" : "A");
    end
    repeat (hold) @(negedge clk);
    if (is_b) req_b = 1'b0; else req_a = 1'b0;
    @(posedge clk); #1;
    $display("access %s wr=%b addr=%0d data=%h done", is_b ? "B" : "A", wr, addr, data);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, owner} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: ack_a/ack_b/busy/owner=%b, required 0000", {ack_a, ack_b, busy, owner});
    end
    n_cmp++;
    if (reg_en !== 8'h00 || reg_data !== 8'h00) begin
      n_err++; $display("FAIL reset_reg: reg_en=%b reg_data=%h, required 0/00", reg_en, reg_data);
    end
    n_cmp++;
    if (rd_a !== 8'h00 || rd_b !== 8'h00) begin
      n_err++; $display("FAIL reset_rd: rd_a=%h rd_b=%h, required 00/00", rd_a, rd_b);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_write_latency();
    exp_q.push_back(mk(1'b0, 1'b1, 3'd3, 8'h5A));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd3, 8'h5A);
    @(negedge clk);
    n_cmp++;
    if (reg_en !== 8'h00 || busy !== 1'b0) begin
      n_err++; $display("FAIL lat_n: reg_en=%b busy=%b, required 0/0", reg_en, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_en !== 8'b0000_1000 || reg_data !== 8'h5A || busy !== 1'b1 || ack_a !== 1'b0 || owner !== 1'b0) begin
      n_err++;
      $display("FAIL lat_access: reg_en=%b data=%h busy=%b ack_a=%b owner=%b, required 00001000/5a/1/0/0",
               reg_en, reg_data, busy, ack_a, owner);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_en !== 8'h00 || ack_a !== 1'b1) begin
      n_err++; $display("FAIL lat_ack: reg_en=%b ack_a=%b, required 0/1", reg_en, ack_a);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (reg_en !== 8'h00 || ack_a !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL hold_%0d: reg_en=%b ack_a=%b busy=%b, required 0/1/1", i, reg_en, ack_a, busy);
      end
    end
    req_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack_a !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin
      n_err++; $display("FAIL release: ack_a=%b busy=%b owner=%b, required 0/0/0", ack_a, busy, owner);
    end
    $display("write A addr 3 data 5a with 10-cycle hold done");
  endtask

  task automatic test_read_b();
    do_access(1'b1, 1'b0, 3'd5, 8'h00, 2);
    n_cmp++;
    if (rd_b !== 8'hC3 || rd_a !== 8'h00 || owner !== 1'b1) begin
      n_err++; $display("FAIL read_b: rd_b=%h rd_a=%h owner=%b, required c3/00/1", rd_b, rd_a, owner);
    end
    do_access(1'b0, 1'b0, 3'd1, 8'h00, 0);
    n_cmp++;
    if (rd_a !== 8'h11 || rd_b !== 8'hC3) begin
      n_err++; $display("FAIL read_a: rd_a=%h rd_b=%h, required 11/c3", rd_a, rd_b);
    end
  endtask

  task automatic tie_pair(input bit first_b);
    bit got;
    bit who;
    exp_q.push_back(mk(first_b, 1'b1, first_b ? 3'd7 : 3'd0, first_b ? 8'hB7 : 8'hA5));
    exp_q.push_back(mk(!first_b, 1'b1, first_b ? 3'd0 : 3'd7, first_b ? 8'hA5 : 8'hB7));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd0, 8'hA5);
    drive(1'b1, 1'b1, 3'd7, 8'hB7);
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? first_b : !first_b;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = who ? ack_b : ack_a;
      end
      n_cmp++;
      if (!got || (who ? ack_a : ack_b) !== 1'b0) begin
        n_err++;
        $display("FAIL tie_order: turn %0d expected %s, ack_a=%b ack_b=%b", k, who ? "B" : "A", ack_a, ack_b);
      end
      if (who) req_b = 1'b0; else req_a = 1'b0;
    end
    @(posedge clk); #1;
    $display("tie pair, %s first, done", first_b ? "B" : "A");
  endtask

  task automatic test_tie();
    do_reset();
    tie_pair(1'b0);
    tie_pair(1'b0);
    do_access(1'b0, 1'b0, 3'd4, 8'h00, 0);
    tie_pair(1'b1);
  endtask

  task automatic test_out_of_range();
    exp_q.push_back(mk(1'b0, 1'b1, 3'd6, 8'h6C));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd6, 8'h6C);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (reg_en4 !== 4'h0 || busy4 !== 1'b1 || reg_en !== 8'h40) begin
      n_err++; $display("FAIL oor_write: reg_en4=%b busy4=%b reg_en=%b, required 0000/1/01000000", reg_en4, busy4, reg_en);
    end
    @(negedge clk);
    n_cmp++;
    if (ack_a4 !== 1'b1 || ack_b4 !== 1'b0 || owner4 !== 1'b0) begin
      n_err++; $display("FAIL oor_ack: ack_a4=%b ack_b4=%b owner4=%b, required 1/0/0", ack_a4, ack_b4, owner4);
    end
    req_a = 1'b0;
    @(posedge clk); #1;
    do_access(1'b0, 1'b0, 3'd6, 8'h00, 0);
    n_cmp++;
    if (rd_a4 !== 8'h00 || rd_a !== 8'h66 || rd_b4 !== 8'h00) begin
      n_err++; $display("FAIL oor_read: rd_a4=%h rd_a=%h rd_b4=%h, required 00/66/00", rd_a4, rd_a, rd_b4);
    end
    do_access(1'b0, 1'b0, 3'd2, 8'h00, 0);
    n_cmp++;
    if (rd_a4 !== 8'h22) begin
      n_err++; $display("FAIL n4_read: rd_a4=%h, required 22", rd_a4);
    end
    do_access(1'b0, 1'b1, 3'd1, 8'h3D, 0);
    n_cmp++;
    if (reg_data4 !== 8'h3D) begin
      n_err++; $display("FAIL n4_write: reg_data4=%h, required 3d", reg_data4);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(mk(1'b0, 1'b1, 3'd2, 8'h27));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd2, 8'h27);
    @(posedge clk); #2;
    n_cmp++;
    if (reg_en !== 8'h04) begin
      n_err++; $display("FAIL mid_access: reg_en=%b, required 00000100", reg_en);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (reg_en !== 8'h00 || reg_data !== 8'h00 || rd_a !== 8'h00 || rd_b !== 8'h00 ||
        {ack_a, ack_b, busy, owner} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset: reg_en=%b data=%h rd_a=%h rd_b=%h flags=%b, required all 0",
               reg_en, reg_data, rd_a, rd_b, {ack_a, ack_b, busy, owner});
    end
    exp_q.delete();
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ack_a !== 1'b0 || reg_en !== 8'h00 || busy !== 1'b0) begin
        n_err++; $display("FAIL post_reset_%0d: ack_a=%b reg_en=%b busy=%b, required 0/0/0", i, ack_a, reg_en, busy);
      end
    end
    do_access(1'b0, 1'b1, 3'd2, 8'h27, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core = '{8'h9E, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC3, 8'h66, 8'h77};
    req_a = 1'b0; wr_a = 1'b0; addr_a = 3'd0; data_a = 8'h00;
    req_b = 1'b0; wr_b = 1'b0; addr_b = 3'd0; data_b = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_write_latency();
    test_read_b();
    test_tie();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d accesses never acknowledged, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wca_reg_arbiter.md
WCA_REG_ARBITER -- requirements
Module: wca_reg_arbiter

Interface
REQ-001 Parameter NREG, default 8, number of 8-bit registers served; legal range 1..8.
REQ-002 Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 Aclr  input  1  asynchronous active-low reset.
REQ-004 ReqA  input  1  requester A access request; held high until AckA seen.
REQ-005 WrA  input  1  requester A: 1 = write, 0 = read; stable while ReqA high.
REQ-006 AddrA  input  3  requester A register address; stable while ReqA high.
REQ-007 DataA  input  8  requester A write data; stable while ReqA high.
REQ-008 AckA  output  1  requester A acknowledge.
REQ-009 RdDataA  output  8  requester A read data; valid while AckA high.
REQ-010 ReqB, WrB, AddrB, DataB, AckB, RdDataB: same directions, widths and meanings as the A ports, for requester B.
REQ-011 RegEn  output  NREG  one-hot write enable to register cores.
REQ-012 RegData  output  8  write data to register cores.
REQ-013 RegQ  input  8*NREG  register core outputs; register i at bits [8i+7:8i].
REQ-014 Busy  output  1  high whenever the state is not IDLE.
REQ-015 Owner  output  1  current or last grant: 0 = A, 1 = B.

Function
REQ-016 States IDLE, ACCESS, ACK; all outputs driven from registers.
REQ-017 IDLE: with neither Req high, stay in IDLE; with any Req high, grant one requester, latch its Wr/Addr/Data, set Owner, go to ACCESS.
REQ-018 Arbitration: single requester wins; on simultaneous ReqA and ReqB, grant the requester not served last (round-robin).
REQ-019 ACCESS lasts exactly one cycle, then unconditionally ACK.
REQ-020 Write with Addr < NREG: during the ACCESS cycle, RegEn bit Addr high and all others low; RegData = latched data.
REQ-021 RegEn all zero in every cycle except an ACCESS write cycle; RegEn never has more than one bit set.
REQ-022 Read with Addr < NREG: RegQ[8*Addr+7:8*Addr] captured at the end of the ACCESS cycle into the owner's RdData; the other requester's RdData holds its previous value.
REQ-023 Addr >= NREG: no RegEn bit asserted; read returns 8'h00; access still completes and is acknowledged.
REQ-024 ACK: owner's Ack high; the other Ack low; remain in ACK while the owner's Req is high.
REQ-025 Owner's Req sampled low in ACK -> IDLE on the next edge; Ack low from that edge.
REQ-026 The non-owner's Req during ACCESS/ACK is held off and evaluated only in IDLE; at most one access every 3 cycles.
REQ-027 Latency: Req high sampled in IDLE at edge n -> RegEn/ACCESS from edge n+1 -> Ack high from edge n+2.
REQ-028 RegData holds its last value outside ACCESS write cycles.

Reset
REQ-029 Aclr low at any time, including mid-access: state IDLE; RegEn, RegData, AckA, AckB, RdDataA, RdDataB all 0; Busy 0; Owner 0; last-served = B, so A wins the first tie.
REQ-030 An access interrupted by reset is abandoned with no RegEn pulse after reset; requesters reissue.
REQ-031 Reset deassertion needs no synchronous settling: the first edge after release may sample Req.

Verification
REQ-032 Reset, ReqA write Addr 3 Data 8'h5A -> RegEn = 8'b0000_1000 for exactly one cycle at edge n+1, RegData = 8'h5A, AckA high from n+2 until ReqA drops, Owner 0.
REQ-033 RegQ byte 5 = 8'hC3, ReqB read Addr 5 -> RegEn stays 0, RdDataB = 8'hC3 with AckB high, RdDataA unchanged.
REQ-034 ReqA and ReqB raised together from reset, both held -> A served first, then B; repeat with both raised together again -> A then B again (alternation on ties).
REQ-035 NREG = 4, ReqA write Addr 6 -> no RegEn bit set, AckA still asserted; read Addr 6 -> RdDataA = 8'h00.
REQ-036 Aclr asserted during ACCESS of a write -> RegEn 0 immediately, AckA never asserts, all outputs 0; after release, a new ReqA completes normally.
REQ-037 ReqA held high for 10 cycles after AckA -> single RegEn pulse only; Busy high throughout; IDLE one edge after ReqA drops.
